// File: rtl/vlog_fifo_pkg.sv
// Shared types and width helpers for the shifting FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vlog_fifo_pkg;

    // Shift applied to a word as it leaves the FIFO.
    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRL  = 2'b10,
        SH_SRA  = 2'b11
    } shift_mode_t;

    // Pointer width: enough to address DEPTH entries, never less than 1 bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

    // Shift-amount width for a given word width (WIDTH >= 2 keeps this >= 1).
    function automatic int shamt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/vlog_shifter.sv
// Combinational shifter applied to the FIFO head word: pass, <<, >>, >>>.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; result follows inputs.
//
// Ports:
//   data   - source word
//   mode   - shift selection
//   shamt  - shift distance; 0 passes the word unchanged
//   result - shifted word, same width as data, shifted-out bits dropped
module vlog_shifter
    import vlog_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]                   data,
    input  shift_mode_t                        mode,
    input  logic [shamt_width(WIDTH)-1:0]      shamt,
    output logic [WIDTH-1:0]                   result
);

    always_comb begin
        result = data;
        case (mode)
            SH_PASS: result = data;
            SH_SLL:  result = data << shamt;
            SH_SRL:  result = data >> shamt;
            // Signed view of the source makes >>> replicate bit WIDTH-1.
            SH_SRA:  result = $unsigned($signed(data) >>> shamt);
            default: result = data;
        endcase
    end

endmodule

// File: rtl/vlog_shift_fifo.sv
// Synchronous FIFO whose registered output applies a per-pop shift to the head word.
// Latency: pop_data/pop_valid appear one cycle after an accepted pop.
// Backpressure: pushes rejected when full, pops rejected when empty; each rejection sets a sticky flag.
//
// Ports:
//   clk, rst_n       - clock (rising edge) and asynchronous active-low reset
//   clr              - synchronous flush, overrides push/pop and clears sticky flags
//   push, push_data  - write request and data
//   pop, mode, shamt - read request plus shift selection sampled with it
//   pop_valid        - one-cycle pulse per accepted pop; pop_data holds otherwise
//   count, full, empty, almost_full, almost_empty - occupancy and derived status
//   overflow, underflow - sticky rejected-push / rejected-pop indicators
module vlog_shift_fifo
    import vlog_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic [1:0]                     mode,
    input  logic [shamt_width(WIDTH)-1:0]  shamt,
    output logic                           pop_valid,
    output logic [WIDTH-1:0]               pop_data,
    output logic [cnt_width(DEPTH)-1:0]    count,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    // Storage is deliberately left out of reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_valid_q, pop_valid_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             push_ok;
    logic             pop_ok;
    logic             mem_we;
    logic [WIDTH-1:0] head_shifted;

    // Acceptance depends only on the pre-edge count, so a push into a full
    // FIFO is rejected even if a pop frees a slot in the same cycle, and a
    // pop from an empty FIFO is rejected even alongside a push.
    assign push_ok = push && (count_q != DEPTH_C);
    assign pop_ok  = pop  && (count_q != '0);
    assign mem_we  = push_ok && !clr;

    vlog_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .data   (mem_q[rd_ptr_q]),
        .mode   (shift_mode_t'(mode)),
        .shamt  (shamt),
        .result (head_shifted)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pop_data_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
                pop_valid_d = 1'b1;
                pop_data_d  = head_shifted;
            end

            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (push && !push_ok) overflow_d  = 1'b1;
            if (pop  && !pop_ok)  underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_valid    = pop_valid_q;
    assign pop_data     = pop_data_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (int'(count_q) >= AFULL_LVL);
    assign almost_empty = (int'(count_q) <= AEMPTY_LVL);

endmodule

// File: tb/tb_vlog_shift_fifo.sv
// Directed bench for vlog_shift_fifo at WIDTH=8, DEPTH=5 (non-power-of-two).
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: full/empty rejection and sticky flags exercised directly.
module tb_vlog_shift_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [1:0] mode;
    logic [2:0] shamt;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic [2:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int total = 0;
    int bad   = 0;

    vlog_shift_fifo #(
        .WIDTH      (8),
        .DEPTH      (5),
        .AFULL_LVL  (3),
        .AEMPTY_LVL (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .mode         (mode),
        .shamt        (shamt),
        .pop_valid    (pop_valid),
        .pop_data     (pop_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request; inputs return idle afterwards.
    task automatic cyc(input logic p, input logic [7:0] d, input logic q,
                       input logic [1:0] m, input logic [2:0] s);
        push = p; push_data = d; pop = q; mode = m; shamt = s;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 2'b00, 3'd0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; push = 1'b0; push_data = '0;
        pop = 1'b0; mode = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_pvld", pop_valid, 0);
        chk("rst_pdata", pop_data, 8'h00);
        chk("rst_flags", {overflow, underflow}, 2'b00);
        rst_n = 1'b1;

        // In-order pass-through
        cyc(1, 8'h81, 0, 2'b00, 3'd0);
        cyc(1, 8'h7F, 0, 2'b00, 3'd0);
        chk("t1_aempty_at2", almost_empty, 1);
        chk("t1_pvld_on_push", pop_valid, 0);
        cyc(1, 8'h01, 0, 2'b00, 3'd0);
        chk("t1_count3", count, 3);
        chk("t1_aempty_at3", almost_empty, 0);
        chk("t1_afull_at3", almost_full, 1);
        cyc(0, 8'h00, 1, 2'b00, 3'd0);
        chk("t1_pvld0", pop_valid, 1);
        chk("t1_data0", pop_data, 8'h81);
        cyc(0, 8'h00, 1, 2'b00, 3'd0);
        chk("t1_data1", pop_data, 8'h7F);
        cyc(0, 8'h00, 1, 2'b00, 3'd0);
        chk("t1_data2", pop_data, 8'h01);
        chk("t1_count0", count, 0);
        chk("t1_empty", empty, 1);
        cyc(0, 8'h00, 0, 2'b00, 3'd0);
        chk("t1_pvld_idle", pop_valid, 0);
        chk("t1_hold", pop_data, 8'h01);

        // Shift modes
        cyc(1, 8'h81, 0, 2'b00, 3'd0);
        cyc(0, 8'h00, 1, 2'b11, 3'd1);
        chk("sra_81_1", pop_data, 8'hC0);
        cyc(1, 8'h81, 0, 2'b00, 3'd0);
        cyc(0, 8'h00, 1, 2'b10, 3'd1);
        chk("srl_81_1", pop_data, 8'h40);
        cyc(1, 8'h81, 0, 2'b00, 3'd0);
        cyc(0, 8'h00, 1, 2'b01, 3'd3);
        chk("sll_81_3", pop_data, 8'h08);
        cyc(1, 8'h7F, 0, 2'b00, 3'd0);
        cyc(0, 8'h00, 1, 2'b11, 3'd2);
        chk("sra_7f_2", pop_data, 8'h1F);
        cyc(1, 8'hA5, 0, 2'b00, 3'd0);
        cyc(0, 8'h00, 1, 2'b01, 3'd0);
        chk("sll_shamt0", pop_data, 8'hA5);
        chk("shift_flags", {overflow, underflow}, 2'b00);

        // Fill, overflow, wrap with DEPTH=5
        for (int i = 0; i < 5; i++) cyc(1, 8'h10 + 8'(i), 0, 2'b00, 3'd0);
        chk("t3_full", full, 1);
        chk("t3_count5", count, 5);
        cyc(1, 8'hAA, 0, 2'b00, 3'd0);
        chk("t3_overflow", overflow, 1);
        chk("t3_count_hold", count, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 1, 2'b00, 3'd0);
            chk("t3_pop_head", pop_data, 8'h10 + 8'(i));
            cyc(1, 8'h20 + 8'(i), 0, 2'b00, 3'd0);
        end
        begin
            logic [7:0] exp_wrap [5];
            exp_wrap = '{8'h13, 8'h14, 8'h20, 8'h21, 8'h22};
            for (int i = 0; i < 5; i++) begin
                cyc(0, 8'h00, 1, 2'b00, 3'd0);
                chk("t3_wrap_data", pop_data, exp_wrap[i]);
            end
        end
        chk("t3_empty", empty, 1);
        do_clr();
        chk("t3_clr_ovf", overflow, 0);

        // Push and pop on empty
        cyc(1, 8'h55, 1, 2'b00, 3'd0);
        chk("t4_count1", count, 1);
        chk("t4_pvld", pop_valid, 0);
        chk("t4_underflow", underflow, 1);
        cyc(0, 8'h00, 1, 2'b00, 3'd0);
        chk("t4_pvld_next", pop_valid, 1);
        chk("t4_data", pop_data, 8'h55);
        do_clr();

        // Push and pop on full: first push is rejected, so occupancy drops
        // to DEPTH-1 and then holds with one output per cycle.
        for (int i = 0; i < 5; i++) cyc(1, 8'h30 + 8'(i), 0, 2'b00, 3'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'h40 + 8'(i), 1, 2'b00, 3'd0);
            chk("t5_pvld", pop_valid, 1);
            chk("t5_data", pop_data, (i < 5) ? 8'h30 + 8'(i) : 8'h40 + 8'(i - 4));
            chk("t5_count", count, 4);
            if (i == 0) chk("t5_ovf_first", overflow, 1);
        end
        do_clr();

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) cyc(1, 8'h60 + 8'(i), 0, 2'b00, 3'd0);
        cyc(0, 8'h00, 1, 2'b00, 3'd0);
        chk("t6_count3", count, 3);
        chk("t6_pvld_pre", pop_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_pvld", pop_valid, 0);
        chk("t6_async_pdata", pop_data, 8'h00);
        chk("t6_async_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // clr with pending push, both sticky flags set beforehand
        cyc(0, 8'h00, 1, 2'b00, 3'd0);
        for (int i = 0; i < 6; i++) cyc(1, 8'h70 + 8'(i), 0, 2'b00, 3'd0);
        chk("t7_flags_set", {overflow, underflow}, 2'b11);
        clr = 1'b1;
        cyc(1, 8'h99, 0, 2'b00, 3'd0);
        chk("t7_clr_count", count, 0);
        chk("t7_clr_flags", {overflow, underflow}, 2'b00);
        chk("t7_clr_empty", empty, 1);
        cyc(0, 8'h00, 1, 2'b00, 3'd0);
        chk("t7_push_ignored", pop_valid, 0);
        chk("t7_udf_after", underflow, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
